dmem_mmio: RTL
==============

# dmem_mmio

Data-side responder for the single-cycle MIPS core: the block at the other end of the CPU's `memwrite`/`memaddr`/`memwritedata`/`memreaddata` data port. Decodes each CPU access to a word-addressed data RAM or a small memory-mapped I/O region (LED register, programmable timer). Reads are combinational within the same cycle, as the single-cycle core requires. Writes commit on the rising clock edge.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; power of two, 4..16384.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  write strobe from the CPU; the write commits at the next rising edge.
- `memaddr`  in  32  byte address from the CPU; bits [1:0] are ignored, so all accesses are word accesses.
- `memwritedata`  in  32  write data.
- `memreaddata`  out  32  read data; a combinational function of `memaddr` and current state.
- `led`  out  8  LED register value.
- `timer_irq`  out  1  timer interrupt level.

## Operation
- **Decode** on `memaddr[31:16]`:
  - `0x0000`: RAM. Word index is `memaddr[log2(RAM_WORDS)+1:2]`; higher bits inside the region alias.
  - `0xFFFF`: MMIO, decoded on `memaddr[7:2]`.
  - Anything else is unmapped: reads return 0, writes are ignored.
- **MMIO registers** (offsets within the MMIO region):
  - `0x00` LED (RW): bits [7:0]; reads return zero in bits [31:8].
  - `0x04` TCTRL (RW): bit0 enable, bit1 auto-clear on match, bit2 irq enable; other bits read 0.
  - `0x08` TCOUNT (RW): 32-bit counter.
  - `0x0C` TCMP (RW): 32-bit compare value.
  - `0x10` TSTAT (R/W1C): bit0 match flag; other bits read 0.
  - Other MMIO offsets read 0 and ignore writes.
- **Timer**:
  - While enable=1, TCOUNT increments by 1 each cycle and wraps 0xFFFFFFFF→0.
  - Match condition: enable=1 and TCOUNT==TCMP, evaluated on the pre-increment value.
  - On match, the TSTAT flag is set at the next edge. If auto-clear=1, TCOUNT loads 0 instead of incrementing.
  - `timer_irq` = TSTAT.bit0 & TCTRL.bit2, driven combinationally from registers.
- **Simultaneous events** (same cycle):
  - CPU write to TCOUNT and an increment or auto-clear: the CPU value is loaded.
  - W1C of TSTAT and a new match: the flag ends set.
  - Write to TCTRL clearing enable: the counter still updates per the old enable in that cycle.
- **Reset**:
  - `led`=0, TCTRL=0, TCOUNT=0, TCMP=0xFFFFFFFF, TSTAT=0, `timer_irq`=0.
  - RAM contents are not reset; they are undefined until written.
  - Reset asserted mid-count: all timer state returns to reset values at that edge; any same-cycle CPU write is discarded.

## Timing
- **Read latency**: 0 cycles. `memreaddata` reflects `memaddr` combinationally and shows pre-edge register and RAM values.
- **Write latency**: 1 edge. Data written at edge N is readable in cycle N+1.
- **No handshake**: every access completes in one cycle, with no stall or wait signal.
- **Match to interrupt**: TCOUNT==TCMP during cycle N, so TSTAT=1 and `timer_irq` rise after edge N.

## Configuration
- `MMIO_TIMER_EN` defined: the timer registers, the timer sub-module and `timer_irq` behave as specified above.
- Macro undefined:
  - No timer logic is built.
  - Offsets 0x04–0x10 read 0 and ignore writes.
  - `timer_irq` is tied to 0.
  - LED and RAM are unchanged.

## Structure
- **Shared package** `dmem_mmio_pkg`:
  - region tags `0x0000` and `0xFFFF`;
  - MMIO offset constants `LED_OFF`, `TCTRL_OFF`, `TCOUNT_OFF`, `TCMP_OFF`, `TSTAT_OFF`;
  - TCTRL bit positions `TCTRL_EN`, `TCTRL_AUTOCLR`, `TCTRL_IRQEN`;
  - TCMP reset value.
- **Sub-module** `mmio_timer`: holds TCTRL, TCOUNT, TCMP and TSTAT with their write ports, read mux and irq output. It is instantiated only under `MMIO_TIMER_EN`.
- **Top level**: decode, the RAM array, the LED register and the read-data mux.

## Test plan
- Write 0x12345678 to 0x00000004, then read it back → 0x12345678. Read 0x00000004+RAM_WORDS*4 → same value (alias). Read 0x10000000 → 0.
- Write 0xABCD to 0xFFFF0000 → `led`=0xCD on the next cycle; reading the address returns 0x000000CD. Assert `reset` → `led`=0.
- TCMP=5, TCTRL=0x7 with TCOUNT=0:
  - TSTAT=1 and `timer_irq`=1 one cycle after TCOUNT reads 5;
  - TCOUNT reads 0 next.
  - Write 1 to TSTAT → `timer_irq`=0.
- TCOUNT=0xFFFFFFFE, enable=1, auto-clear=0 → reads 0xFFFFFFFF, then 0x00000000, then 1.
- Simultaneous events:
  - Write TCOUNT=100 in the same cycle as an increment → reads 100.
  - W1C of TSTAT in the same cycle as a match → flag stays 1.
- Build without `MMIO_TIMER_EN`:
  - write 0x7 to TCTRL and 0x3 to TCOUNT;
  - read all of TCTRL, TCOUNT, TCMP and TSTAT → each reads 0;
  - `timer_irq`=0 throughout.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the dmem_mmio data-side responder: region tags,
// MMIO register offsets, TCTRL bit positions and timer reset values.
package dmem_mmio_pkg;

  localparam logic [15:0] RAM_REGION  = 16'h0000;
  localparam logic [15:0] MMIO_REGION = 16'hFFFF;

  localparam logic [7:0] LED_OFF    = 8'h00;
  localparam logic [7:0] TCTRL_OFF  = 8'h04;
  localparam logic [7:0] TCOUNT_OFF = 8'h08;
  localparam logic [7:0] TCMP_OFF   = 8'h0C;
  localparam logic [7:0] TSTAT_OFF  = 8'h10;

  localparam int unsigned TCTRL_EN      = 0;
  localparam int unsigned TCTRL_AUTOCLR = 1;
  localparam int unsigned TCTRL_IRQEN   = 2;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_MMIO
  } region_e;

  function automatic region_e decode_region(input logic [15:0] tag);
    if (tag == RAM_REGION)       return REG_RAM;
    else if (tag == MMIO_REGION) return REG_MMIO;
    else                         return REG_NONE;
  endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// Programmable MMIO timer (TCTRL/TCOUNT/TCMP/TSTAT); only compiled when
// MMIO_TIMER_EN is defined.
`ifdef MMIO_TIMER_EN
module mmio_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [5:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [2:0]  tctrl_q,  tctrl_d;
  logic [31:0] tcount_q, tcount_d;
  logic [31:0] tcmp_q,   tcmp_d;
  logic        tstat_q,  tstat_d;
  logic        match;
  logic [7:0]  off_b;

  assign off_b = {off_i, 2'b00};
  assign match = tctrl_q[TCTRL_EN] && (tcount_q == tcmp_q);

  // Priority: counter update, then CPU write overrides it; a match beats W1C.
  always_comb begin
    tctrl_d  = tctrl_q;
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    tstat_d  = tstat_q;
    if (tctrl_q[TCTRL_EN]) begin
      tcount_d = (match && tctrl_q[TCTRL_AUTOCLR]) ? '0 : tcount_q + 32'd1;
    end
    if (we_i) begin
      case (off_b)
        TCTRL_OFF:  tctrl_d  = wdata_i[2:0];
        TCOUNT_OFF: tcount_d = wdata_i;
        TCMP_OFF:   tcmp_d   = wdata_i;
        TSTAT_OFF:  if (wdata_i[0]) tstat_d = 1'b0;
        default:    ;
      endcase
    end
    if (match) tstat_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tctrl_q  <= '0;
      tcount_q <= '0;
      tcmp_q   <= TCMP_RST;
      tstat_q  <= 1'b0;
    end else begin
      tctrl_q  <= tctrl_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      tstat_q  <= tstat_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_b)
      TCTRL_OFF:  rdata_o = {29'd0, tctrl_q};
      TCOUNT_OFF: rdata_o = tcount_q;
      TCMP_OFF:   rdata_o = tcmp_q;
      TSTAT_OFF:  rdata_o = {31'd0, tstat_q};
      default:    rdata_o = '0;
    endcase
  end

  assign irq_o = tstat_q & tctrl_q[TCTRL_IRQEN];

endmodule
`endif

// File: rtl/dmem_mmio.sv
// Data-side responder: word RAM at 0x0000xxxx, LED/timer MMIO at 0xFFFFxxxx.
// Timer is built only when MMIO_TIMER_EN is defined.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [7:0]  led,
  output logic        timer_irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  region_e       region;
  logic [AW-1:0] ram_idx;
  logic [5:0]    mmio_off;
  logic          ram_we;
  logic          mmio_we;
  logic [7:0]    led_q, led_d;
  logic [31:0]   timer_rdata;
  logic [31:0]   ram_q [RAM_WORDS];
  logic          addr_unused;

  assign region   = decode_region(memaddr[31:16]);
  assign ram_idx  = memaddr[AW+1:2];
  assign mmio_off = memaddr[7:2];
  assign ram_we   = memwrite && (region == REG_RAM) && !reset;
  assign mmio_we  = memwrite && (region == REG_MMIO);

  assign addr_unused = ^{memaddr[1:0], memaddr[15:8], memwritedata[31:8]};

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= memwritedata;
  end

  always_comb begin
    led_d = led_q;
    if (mmio_we && ({mmio_off, 2'b00} == LED_OFF)) led_d = memwritedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) led_q <= '0;
    else       led_q <= led_d;
  end

  assign led = led_q;

`ifdef MMIO_TIMER_EN
  mmio_timer u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (mmio_we),
    .off_i   (mmio_off),
    .wdata_i (memwritedata),
    .rdata_o (timer_rdata),
    .irq_o   (timer_irq)
  );
`else
  assign timer_rdata = '0;
  assign timer_irq   = 1'b0;
`endif

  // Timer mux already returns 0 for the LED offset and unused offsets.
  always_comb begin
    memreaddata = '0;
    case (region)
      REG_RAM:  memreaddata = ram_q[ram_idx];
      REG_MMIO: memreaddata = ({mmio_off, 2'b00} == LED_OFF) ? {24'd0, led_q}
                                                               : timer_rdata;
      default:  memreaddata = '0;
    endcase
  end

endmodule
